fp_norm_pipe: RTL and testbench



---
 rtl/fp_norm_pkg.sv | 17 +
 rtl/lza_32.sv | 17 +
 rtl/fp_norm_pipe.sv | 131 +++++++++++++
 tb/tb_fp_norm_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared constants and the stage payload type for the FPU mantissa normalizer.
package fp_norm_pkg;

  localparam int MANT_W    = 32;
  localparam int CNT_W     = 6;
  localparam int EXP_W_DEF = 10;

  localparam logic [CNT_W-1:0] ZERO_CNT = 6'd32;

  typedef struct packed {
    logic                 sign;
    logic [MANT_W-1:0]    mant;
    logic [EXP_W_DEF-1:0] exp;
    logic [CNT_W-1:0]     cnt;
  } stage_t;

endpackage

// File: rtl/lza_32.sv
// Leading-zero counter for a 32-bit mantissa; yields 32 when the input is zero.
module lza_32
  import fp_norm_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  output logic [CNT_W-1:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last one to write cnt_o.
  always_comb begin
    cnt_o = ZERO_CNT;
    for (int i = 0; i < MANT_W; i++) begin
      if (mant_i[i]) cnt_o = CNT_W'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage mantissa normalizer with valid/ready on both sides.
// Define FP_NORM_DENORM_EN to clamp the shift so underflowing results stay denormal.
module fp_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uflow
);

  // The shared payload type carries a fixed exponent width.
  if (EXP_W != EXP_W_DEF) begin : g_exp_w_chk
    $error("fp_norm_pipe: EXP_W must equal fp_norm_pkg::EXP_W_DEF");
  end

  logic             s1_valid_q, s2_valid_q;
  logic             s1_adv, s2_adv;
  logic [CNT_W-1:0] lz_cnt;
  stage_t           s1_q, s1_d;

  logic              sign_q, zero_q, uflow_q;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              zero_d, uflow_d;
  logic [CNT_W-1:0]  sh;
  logic [EXP_W-1:0]  exp_sub;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  lza_32 u_lza (
    .mant_i (in_mant),
    .cnt_o  (lz_cnt)
  );

  assign s1_d = '{sign: in_sign, mant: in_mant, exp: in_exp, cnt: lz_cnt};

  // ---- stage 1: capture payload plus leading-zero count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      s1_q       <= s1_d;
    end
  end

  assign exp_sub = s1_q.exp - {{(EXP_W-CNT_W){1'b0}}, s1_q.cnt};
  assign zero_d  = (s1_q.cnt == ZERO_CNT);

`ifdef FP_NORM_DENORM_EN
  logic [EXP_W:0]   exp_wide;
  logic [EXP_W-1:0] exp_m1;
  logic             clamp;

  // Extra bit so the "below 1" test is not fooled by exponent wrap.
  assign exp_wide = {s1_q.exp[EXP_W-1], s1_q.exp} - {{(EXP_W+1-CNT_W){1'b0}}, s1_q.cnt};
  assign exp_m1   = s1_q.exp - 1'b1;
  assign clamp    = !zero_d && (exp_wide[EXP_W] || (exp_wide == '0));

  always_comb begin
    sh      = s1_q.cnt;
    exp_d   = exp_sub;
    uflow_d = 1'b0;
    if (zero_d) begin
      exp_d = '0;
    end else if (clamp) begin
      // exp - 1 < cnt here, so the clamped shift always fits CNT_W bits.
      sh      = (!s1_q.exp[EXP_W-1] && !exp_m1[EXP_W-1] && (exp_m1 != '0))
                ? exp_m1[CNT_W-1:0] : '0;
      exp_d   = '0;
      uflow_d = 1'b1;
    end
  end
`else
  always_comb begin
    sh      = s1_q.cnt;
    exp_d   = exp_sub;
    uflow_d = 1'b0;
    if (zero_d) begin
      exp_d = '0;
    end else begin
      uflow_d = exp_sub[EXP_W-1] || (exp_sub == '0);
    end
  end
`endif

  assign mant_d = s1_q.mant << sh;

  // ---- stage 2: shifted mantissa, adjusted exponent and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      zero_q     <= 1'b0;
      uflow_q    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      sign_q     <= s1_q.sign;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      zero_q     <= zero_d;
      uflow_q    <= uflow_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = sign_q;
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_zero  = zero_q;
  assign out_uflow = uflow_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Scoreboard bench for fp_norm_pipe: directed beats, stall, back-to-back and reset flush.
module tb_fp_norm_pipe;

  typedef struct {
    logic        sign;
    logic [31:0] mant;
    logic [9:0]  exp;
    logic        zero;
    logic        uflow;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [31:0] in_mant;
  logic [9:0]  in_exp;
  logic        out_valid, out_ready, out_sign, out_zero, out_uflow;
  logic [31:0] out_mant;
  logic [9:0]  out_exp;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  fp_norm_pipe #(.EXP_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic s, logic [31:0] m, logic [9:0] e, logic z, logic u);
    exp_t x;
    x.sign = s; x.mant = m; x.exp = e; x.zero = z; x.uflow = u;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Presents one beat from just after a rising edge until it is accepted.
  task automatic send(logic s, logic [31:0] m, logic [9:0] e, exp_t x);
    bit done = 0;
    in_valid = 1'b1; in_sign = s; in_mant = m; in_exp = e;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: beat mant=%h never accepted", m);
    end
  endtask

  // Monitor: compare each consumed beat, and check outputs hold during a stall.
  bit          prev_stall = 0;
  logic [44:0] prev_vec;
  always @(negedge clk) begin
    logic [44:0] cur;
    exp_t        e;
    if (rst) begin
      prev_stall = 0;
    end else if (out_valid) begin
      cur = {out_sign, out_mant, out_exp, out_zero, out_uflow};
      if (prev_stall) chk("stall_hold", 64'(cur), 64'(prev_vec));
      if (out_ready) begin
        prev_stall = 0;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %h, expected no output", cur);
        end else begin
          e = sb.pop_front();
          chk("beat", 64'(cur), 64'({e.sign, e.mant, e.exp, e.zero, e.uflow}));
        end
      end else begin
        prev_stall = 1;
        prev_vec   = cur;
      end
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({out_sign, out_mant, out_exp, out_zero, out_uflow}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic vectors, streamed back-to-back.
    send(0, 32'h0000_0001, 10'd100, mk(0, 32'h8000_0000, 10'd69, 0, 0));
    send(1, 32'h0000_0000, 10'd37,  mk(1, 32'h0000_0000, 10'd0,  1, 0));
    send(0, 32'h8000_0000, 10'd5,   mk(0, 32'h8000_0000, 10'd5,  0, 0));
    send(0, 32'hC000_0000, 10'd6,   mk(0, 32'hC000_0000, 10'd6,  0, 0));
    send(0, 32'h0001_0000, 10'd16,  mk(0, 32'h8000_0000, 10'd1,  0, 0));
`ifdef FP_NORM_DENORM_EN
    send(0, 32'h0000_00FF, 10'd10,  mk(0, 32'h0001_FE00, 10'd0,  0, 1));
    send(0, 32'h4000_0000, 10'd1,   mk(0, 32'h4000_0000, 10'd0,  0, 1));
    send(1, 32'h0000_0001, 10'h20C, mk(1, 32'h0000_0001, 10'd0,  0, 1));
`else
    send(0, 32'h0000_00FF, 10'd10,  mk(0, 32'hFF00_0000, 10'h3F2, 0, 1));
    send(0, 32'h4000_0000, 10'd1,   mk(0, 32'h8000_0000, 10'd0,   0, 1));
    send(1, 32'h0000_0001, 10'h20C, mk(1, 32'h8000_0000, 10'h1ED, 0, 0));
`endif
    repeat (4) @(posedge clk);
    #1;

    // Stall: A and B fill the pipe, C must wait and survive.
    out_ready = 1'b0;
    send(1, 32'h0000_0002, 10'd40, mk(1, 32'h8000_0000, 10'd10, 0, 0));
`ifdef FP_NORM_DENORM_EN
    send(0, 32'h0F00_0000, 10'd3,  mk(0, 32'h3C00_0000, 10'd0,   0, 1));
`else
    send(0, 32'h0F00_0000, 10'd3,  mk(0, 32'hF000_0000, 10'h3FF, 0, 1));
`endif
    fork
      send(0, 32'h0000_8000, 10'd20, mk(0, 32'h8000_0000, 10'd4, 0, 0));
      begin
        @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("stall_in_ready2", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset with both stages full: everything in flight is discarded.
    out_ready = 1'b0;
    send(0, 32'h0000_0100, 10'd50, mk(0, 32'h8000_0000, 10'd27, 0, 0));
    send(1, 32'h0000_0010, 10'd60, mk(1, 32'h8000_0000, 10'd33, 0, 0));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_mant", 64'(out_mant), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_beat", 64'(out_valid), 64'd0);

    // Drain check.
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d beats outstanding, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
